wb_size_bridge_arbiter: RTL
===========================

Name: wb_size_bridge_arbiter

Overview:
- Two-master Wishbone arbiter placed in front of the 32-bit hi-side slave port of the 32-to-16/8 size bridge.
- Lets two 32-bit masters (e.g. CPU and DMA) share one narrow peripheral bus.
- Grant is round-robin and held for the master's whole cycle, so a multi-chunk bridge sequence is never split between masters.
- A watchdog terminates hung transfers with an error and a bridge-abort pulse.

Parameters:
- TIMEOUT_CYCLES, 255: stalled-strobe cycles before the watchdog fires; legal range 2..2^TO_WIDTH-1.
- TO_WIDTH, 8: watchdog counter width.

Ports:
- wb_hi_clk_i  in  1  clock.
- wb_hi_rst_i  in  1  asynchronous, active-high reset.
- wb_m0_cyc_i / wb_m1_cyc_i  in  1  master cycle.
- wb_m0_stb_i / wb_m1_stb_i  in  1  master strobe.
- wb_m0_we_i / wb_m1_we_i  in  1  master write enable.
- wb_m0_sel_i / wb_m1_sel_i  in  4  byte selects.
- wb_m0_adr_i / wb_m1_adr_i  in  32  address.
- wb_m0_dat_i / wb_m1_dat_i  in  32  write data.
- wb_m0_dat_o / wb_m1_dat_o  out  32  read data (slave read data, broadcast to both).
- wb_m0_ack_o / wb_m1_ack_o  out  1  ack, routed to the granted master only.
- wb_m0_err_o / wb_m1_err_o  out  1  error, routed to the granted master only.
- wb_m0_rty_o / wb_m1_rty_o  out  1  retry, routed to the granted master only.
- wb_s_cyc_o, wb_s_stb_o, wb_s_we_o  out  1  to bridge hi port.
- wb_s_sel_o  out  4  to bridge hi port.
- wb_s_adr_o, wb_s_dat_o  out  32  to bridge hi port.
- wb_s_dat_i  in  32  bridge read data.
- wb_s_ack_i, wb_s_err_i, wb_s_rty_i  in  1  bridge responses.
- bridge_abort_o  out  1  one-cycle pulse on timeout; ORed into the bridge reset at top level.
- timeout_flag_o  out  1  sticky timeout indicator.
- timeout_clr_i  in  1  clears timeout_flag_o.
- grant_o  out  2  one-hot current grant: 00 idle, 01 m0, 10 m1.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, grant_o=00, last_grant=m1 (so m0 wins the first tie).
  - Watchdog counter=0, timeout_flag_o=0.
  - All wb_s_* control outputs, responses, bridge_abort_o=0.
- States, held in a registered grant:
  - IDLE: no cyc -> stay. m0 cyc only -> GNT0. m1 cyc only -> GNT1. Both -> the master not equal to last_grant.
  - GNTn: stay while wb_mn_cyc_i=1 (bus lock across multiple strobes).
  - GNTn, on cyc drop: go directly to the other GNT if the other cyc=1, else IDLE. last_grant<=n.
- Latency:
  - Grant is registered, so a request from IDLE reaches the slave 1 cycle later.
  - Handover is 0 idle cycles: the new master's signals appear on the cycle after the old cyc drops.
- Forwarding:
  - wb_s_* is muxed combinationally from the granted master.
  - In IDLE: cyc/stb/we=0; sel/adr/dat driven from m0 (values irrelevant).
  - wb_s_cyc_o = granted cyc; wb_s_stb_o = granted stb & ~timeout_hit.
- Response routing:
  - wb_mn_ack_o = grant[n] & wb_s_ack_i. err and rty are routed the same way.
  - The non-granted master never sees a response.
- Watchdog:
  - Counter increments each cycle that wb_s_cyc_o & granted stb & ~(ack|err|rty) holds.
  - Counter clears on any response, on stb low, or on a grant change.
  - timeout_hit = (count == TIMEOUT_CYCLES-1) & stalled. In that cycle:
    - the granted master gets err=1;
    - wb_s_stb_o is forced 0;
    - bridge_abort_o=1;
    - the counter clears;
    - timeout_flag_o sets on the next edge.
  - A genuine slave response arriving in the timeout_hit cycle wins: the response is forwarded, no timeout fires.
- timeout_flag_o:
  - Set has priority over timeout_clr_i in the same cycle.
- Reset mid-transfer: grant drops immediately (async), outputs return to reset values.

Decomposition:
- Shared package wb_bridge_pkg holds:
  - state localparams ARB_IDLE, ARB_GNT0, ARB_GNT1;
  - the one-hot grant encodings.
- One natural sub-module, wb_arb_watchdog: counter, timeout_hit, sticky flag.
- The arbiter FSM and muxes stay in the top.

Test Plan:
- m0 cyc/stb single write, sel=4'hF, adr=0x100, bridge acks after 3 cycles -> grant_o=01 one cycle after request; wb_m0_ack_o=1 exactly once; wb_m1_ack_o stays 0.
- m0 and m1 request in the same cycle from reset -> m0 granted first. m0 drops cyc -> m1 granted the next cycle with no IDLE gap. Next tie -> m1 loses to m0 (round-robin alternates).
- m1 holds cyc across 3 back-to-back stb reads while m0 requests -> grant stays 10 until m1 cyc drops; m0 read data 0xDEADBEEF is returned only after handover.
- TIMEOUT_CYCLES=4, slave never acks -> 4th stalled cycle gives wb_m0_err_o=1, bridge_abort_o=1, wb_s_stb_o=0; timeout_flag_o=1 next cycle; timeout_clr_i clears it.
- Ack arrives in the same cycle the counter hits TIMEOUT_CYCLES-1 -> ack forwarded, no err, no abort, flag stays 0.
- wb_hi_rst_i asserted mid-transfer with grant 10 -> grant_o=00 and wb_s_cyc_o=0 without waiting for a clock edge; after release, first tie goes to m0.

Source files
------------

// File: rtl/wb_bridge_pkg.sv
// Shared arbiter state encoding and one-hot grant values for the Wishbone size bridge front end.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts unanswered strobe cycles, flags the terminal cycle, keeps a sticky flag.
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_WIDTH       = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stalled,
  input  logic i_grant_chg,
  input  logic i_flag_clr,
  output logic o_timeout_hit,
  output logic o_timeout_flag
);

  localparam logic [TO_WIDTH-1:0] LP_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TO_WIDTH-1:0] r_count;
  logic                r_flag;

  // A response in the terminal cycle deasserts i_stalled, so the slave wins the race.
  assign o_timeout_hit  = i_stalled & (r_count == LP_LAST);
  assign o_timeout_flag = r_flag;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (!i_stalled || o_timeout_hit || i_grant_chg) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_flag <= 1'b0;
    end else if (o_timeout_hit) begin
      r_flag <= 1'b1;
    end else if (i_flag_clr) begin
      r_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_size_bridge_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the bridge hi port; grant held for the whole
// cycle, registered grant (1 cycle from idle, 0-gap handover), watchdog aborts hung transfers.
module wb_size_bridge_arbiter
  import wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_WIDTH       = 8
) (
  input  logic        wb_hi_clk_i,
  input  logic        wb_hi_rst_i,
  input  logic        wb_m0_cyc_i,
  input  logic        wb_m0_stb_i,
  input  logic        wb_m0_we_i,
  input  logic [3:0]  wb_m0_sel_i,
  input  logic [31:0] wb_m0_adr_i,
  input  logic [31:0] wb_m0_dat_i,
  output logic [31:0] wb_m0_dat_o,
  output logic        wb_m0_ack_o,
  output logic        wb_m0_err_o,
  output logic        wb_m0_rty_o,
  input  logic        wb_m1_cyc_i,
  input  logic        wb_m1_stb_i,
  input  logic        wb_m1_we_i,
  input  logic [3:0]  wb_m1_sel_i,
  input  logic [31:0] wb_m1_adr_i,
  input  logic [31:0] wb_m1_dat_i,
  output logic [31:0] wb_m1_dat_o,
  output logic        wb_m1_ack_o,
  output logic        wb_m1_err_o,
  output logic        wb_m1_rty_o,
  output logic        wb_s_cyc_o,
  output logic        wb_s_stb_o,
  output logic        wb_s_we_o,
  output logic [3:0]  wb_s_sel_o,
  output logic [31:0] wb_s_adr_o,
  output logic [31:0] wb_s_dat_o,
  input  logic [31:0] wb_s_dat_i,
  input  logic        wb_s_ack_i,
  input  logic        wb_s_err_i,
  input  logic        wb_s_rty_i,
  output logic        bridge_abort_o,
  output logic        timeout_flag_o,
  input  logic        timeout_clr_i,
  output logic [1:0]  grant_o
);

  arb_state_e r_state;
  arb_state_e w_next_state;
  logic       r_last_m1;
  logic       w_last_m1_nxt;
  logic       w_sel_m1;
  logic       w_gnt_cyc;
  logic       w_gnt_stb;
  logic       w_gnt_we;
  logic       w_stalled;
  logic       w_grant_chg;
  logic       w_timeout_hit;

  // last_grant resets to m1 so that m0 takes the first tie.
  always_ff @(posedge wb_hi_clk_i or posedge wb_hi_rst_i) begin
    if (wb_hi_rst_i) begin
      r_state   <= ARB_IDLE;
      r_last_m1 <= 1'b1;
    end else begin
      r_state   <= w_next_state;
      r_last_m1 <= w_last_m1_nxt;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_last_m1_nxt = r_last_m1;
    case (r_state)
      ARB_IDLE: begin
        if (wb_m0_cyc_i && wb_m1_cyc_i) begin
          w_next_state = r_last_m1 ? ARB_GNT0 : ARB_GNT1;
        end else if (wb_m0_cyc_i) begin
          w_next_state = ARB_GNT0;
        end else if (wb_m1_cyc_i) begin
          w_next_state = ARB_GNT1;
        end
      end
      ARB_GNT0: begin
        if (!wb_m0_cyc_i) begin
          w_last_m1_nxt = 1'b0;
          w_next_state  = wb_m1_cyc_i ? ARB_GNT1 : ARB_IDLE;
        end
      end
      ARB_GNT1: begin
        if (!wb_m1_cyc_i) begin
          w_last_m1_nxt = 1'b1;
          w_next_state  = wb_m0_cyc_i ? ARB_GNT0 : ARB_IDLE;
        end
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_o = GRANT_NONE;
    case (r_state)
      ARB_GNT0: grant_o = GRANT_M0;
      ARB_GNT1: grant_o = GRANT_M1;
      default:  grant_o = GRANT_NONE;
    endcase
  end

  // Control bits are gated by the grant; payload follows m0 unless m1 owns the bus.
  assign w_sel_m1  = grant_o[1];
  assign w_gnt_cyc = (grant_o[0] & wb_m0_cyc_i) | (grant_o[1] & wb_m1_cyc_i);
  assign w_gnt_stb = (grant_o[0] & wb_m0_stb_i) | (grant_o[1] & wb_m1_stb_i);
  assign w_gnt_we  = (grant_o[0] & wb_m0_we_i)  | (grant_o[1] & wb_m1_we_i);

  assign wb_s_cyc_o = w_gnt_cyc;
  assign wb_s_stb_o = w_gnt_stb & ~w_timeout_hit;
  assign wb_s_we_o  = w_gnt_we;
  assign wb_s_sel_o = w_sel_m1 ? wb_m1_sel_i : wb_m0_sel_i;
  assign wb_s_adr_o = w_sel_m1 ? wb_m1_adr_i : wb_m0_adr_i;
  assign wb_s_dat_o = w_sel_m1 ? wb_m1_dat_i : wb_m0_dat_i;

  assign wb_m0_dat_o = wb_s_dat_i;
  assign wb_m1_dat_o = wb_s_dat_i;
  assign wb_m0_ack_o = grant_o[0] & wb_s_ack_i;
  assign wb_m1_ack_o = grant_o[1] & wb_s_ack_i;
  assign wb_m0_err_o = grant_o[0] & (wb_s_err_i | w_timeout_hit);
  assign wb_m1_err_o = grant_o[1] & (wb_s_err_i | w_timeout_hit);
  assign wb_m0_rty_o = grant_o[0] & wb_s_rty_i;
  assign wb_m1_rty_o = grant_o[1] & wb_s_rty_i;

  assign w_stalled      = w_gnt_cyc & w_gnt_stb & ~(wb_s_ack_i | wb_s_err_i | wb_s_rty_i);
  assign w_grant_chg    = (w_next_state != r_state);
  assign bridge_abort_o = w_timeout_hit;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_WIDTH       (TO_WIDTH)
  ) u_watchdog (
    .i_clk          (wb_hi_clk_i),
    .i_rst          (wb_hi_rst_i),
    .i_stalled      (w_stalled),
    .i_grant_chg    (w_grant_chg),
    .i_flag_clr     (timeout_clr_i),
    .o_timeout_hit  (w_timeout_hit),
    .o_timeout_flag (timeout_flag_o)
  );

endmodule
